imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
- Shares the instruction RAM debug port (port B: byte address, write data, 4-bit byte write-enable, synchronous read data) between two requesters.
- Requester 0 is the debug/UART program loader. Requester 1 is the self-test/checksum engine.
- Sits beside the IF-ID segment register and drives its A2/WD2/WE2 inputs; RD2 returns one cycle later.
- Provides valid/ready request handshakes, round-robin or fixed priority, burst locking, and response routing that tracks the 1-cycle read latency.

Parameters:
- PRIO_FIXED, 0, 0 = round-robin between requesters; 1 = requester 0 always wins ties.
- LOCK_MAX, 64, maximum consecutive grants under lock before the lock is forcibly released (1..255).

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle (combinational).
- req0_addr  in  32  byte address.
- req0_wdata  in  32  write data.
- req0_we  in  4  byte write-enable; 0 means read.
- req0_lock  in  1  keep the grant for the following request (burst).
- rsp0_valid  out  1  one-cycle response pulse.
- rsp0_rdata  out  32  read data; 0 for writes and errors.
- rsp0_err  out  1  misaligned request.
- req1_valid, req1_ready, req1_addr, req1_wdata, req1_we, req1_lock, rsp1_valid, rsp1_rdata, rsp1_err: same as the requester 0 set, for requester 1.
- mem_a2  out  32  to the RAM A2 port.
- mem_wd2  out  32  to the RAM WD2 port.
- mem_we2  out  4  to the RAM WE2 port.
- mem_rd2  in  32  from the RAM RD2 port; valid one cycle after the address.

Behaviour:
- Reset values:
  - All ready, rsp_valid and rsp_err outputs are 0; rsp_rdata is 0.
  - mem_a2, mem_wd2 and mem_we2 are 0.
  - FSM is in IDLE, round-robin pointer favours requester 0, lock counter is 0, in-flight tag is empty.
- FSM states: IDLE, LOCK0, LOCK1.
  - IDLE: arbitrate among the valid requesters.
  - IDLE -> LOCKn: the granted request has reqn_lock=1.
  - LOCKn: only requester n may be granted; the other requester's ready stays 0.
  - LOCKn -> IDLE: a granted request has lock=0, or the lock counter reaches LOCK_MAX. After a forced release the pointer favours the other requester.
  - LOCKn with reqn_valid=0: the FSM holds state with no grant.
- Arbitration:
  - One grant per cycle at most. readyn = grant to n. Acceptance = valid & ready.
  - Round-robin (PRIO_FIXED=0): on a tie, grant the requester not granted last. The pointer updates only on a grant.
- Issue path:
  - The granted request drives mem_a2, mem_wd2 and mem_we2 combinationally in the same cycle.
  - With no grant, mem_we2 is 0 and mem_a2 holds its last value; mem_a2 is 0 only after reset.
- Misaligned request (addr[1:0]≠0):
  - Accepted normally, but mem_we2 is forced to 0 so no write occurs.
  - The response has err=1 and rdata=0.
- Response:
  - Exactly 1 cycle after acceptance, rspn_valid=1 for one cycle.
  - rdata = mem_rd2 for a read, 0 for a write.
  - The in-flight tag register records requester, read/write and err.
  - Back-to-back grants give back-to-back responses, routed by tag. No response backpressure.
- Simultaneous accept and response in the same cycle is normal pipelining; the tag register is overwritten by the new grant.
- Lock counter: increments per locked grant; cleared when entering IDLE.
- Reset asserted mid-operation: the in-flight response is dropped (no rsp_valid pulse); the RAM write already issued stands.

Optional Feature:
- Macro: IMEM_PORT_ARBITER_STATS_EN.
- Defined:
  - Adds outputs stat0_grants[15:0], stat1_grants[15:0] and stat_conflicts[15:0].
  - stat_conflicts counts cycles where both requesters were valid but only one was granted.
  - All counters saturate at 16'hFFFF and are cleared by rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package imem_arb_pkg:
  - FSM state encoding (IDLE=2'd0, LOCK0=2'd1, LOCK1=2'd2).
  - In-flight tag struct {valid, req_id, is_write, err}.
  - WORD_ALIGN_MASK = 2'b11.
- One natural sub-module, imem_rr_pick: a 2-way round-robin/fixed picker with pointer update, reusable for the data RAM debug port.

Test Plan:
- Reset, then req0 read of addr 0x10 (RAM holds 0xDEADBEEF) -> req0_ready=1 in the same cycle; next cycle rsp0_valid=1 with rdata 0xDEADBEEF.
- Both requesters valid for 4 cycles, PRIO_FIXED=0 -> grants alternate 0,1,0,1; each response arrives on the correct port 1 cycle after its grant.
- req0_lock=1 for 3 writes (0x0, 0x4, 0x8) while req1 is valid -> req1_ready stays 0 until the third write (lock=0); req1 is granted the next cycle.
- LOCK_MAX=4 with req0_lock held permanently and req1 valid -> after 4 grants to req0, req1 is granted next.
- req1 write to addr 0x6 with we=4'hF -> mem_we2=0, rsp1_valid=1, rsp1_err=1; a read back of 0x4 shows the old data unchanged.
- rst asserted the cycle after a read grant -> no rsp_valid pulse; all outputs return to 0 and the FSM to IDLE.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared definitions for the instruction RAM debug-port arbiter: FSM encoding,
// in-flight response tag and the word-alignment helper.
package imem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  // Describes the single request whose RAM read data returns next cycle.
  typedef struct packed {
    logic valid;
    logic req_id;
    logic is_write;
    logic err;
  } tag_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] & WORD_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/imem_rr_pick.sv
// Two-way request picker: round-robin on ties, or fixed priority to requester 0.
// The pointer names the requester favoured on the next tie and moves only on a grant.
module imem_rr_pick #(
  parameter int PRIO_FIXED = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       ptr
);

  logic ptr_q;

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      if ((PRIO_FIXED != 0) || !ptr_q) begin
        gnt = 2'b01;
      end else begin
        gnt = 2'b10;
      end
    end else begin
      gnt = req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (gnt[0]) begin
      ptr_q <= 1'b1;
    end else if (gnt[1]) begin
      ptr_q <= 1'b0;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the instruction RAM debug port (A2/WD2/WE2/RD2) between the program loader
// (requester 0) and the self-test engine (requester 1). Optional grant/conflict
// counters are built when IMEM_PORT_ARBITER_STATS_EN is defined.
//
// Handshake: a request is accepted in any cycle where valid and ready are both high;
// ready is combinational and never depends on anything but the current valids and
// arbiter state. Responses are single-cycle pulses one cycle after acceptance and
// cannot be back-pressured.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int PRIO_FIXED = 0,
  parameter int LOCK_MAX   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [3:0]  req0_we,
  input  logic        req0_lock,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [3:0]  req1_we,
  input  logic        req1_lock,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic [31:0] mem_a2,
  output logic [31:0] mem_wd2,
  output logic [3:0]  mem_we2,
  input  logic [31:0] mem_rd2,
`ifdef IMEM_PORT_ARBITER_STATS_EN
  output logic [15:0] stat0_grants,
  output logic [15:0] stat1_grants,
  output logic [15:0] stat_conflicts,
`endif
  output logic [1:0]  fsm_state,
  output logic        arb_ptr
);

  localparam logic [8:0] LOCK_MAX_W = 9'(LOCK_MAX);

  logic [1:0]  state_q, state_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  tag_t        tag_q, tag_d;
  logic [31:0] a2_q, wd2_q;

  logic [1:0]  req_masked;
  logic [1:0]  gnt;
  logic        any_gnt;
  logic        g_id;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic [3:0]  g_we;
  logic        g_lock;
  logic        g_mis;
  logic        lock_hit;
  logic        data_ok;

  // While locked, the other requester is simply hidden from the picker.
  always_comb begin
    req_masked = 2'b00;
    case (state_q)
      ST_LOCK0: req_masked = {1'b0, req0_valid};
      ST_LOCK1: req_masked = {req1_valid, 1'b0};
      default:  req_masked = {req1_valid, req0_valid};
    endcase
  end

  imem_rr_pick #(
    .PRIO_FIXED(PRIO_FIXED)
  ) u_pick (
    .clk(clk),
    .rst(rst),
    .req(req_masked),
    .gnt(gnt),
    .ptr(arb_ptr)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign any_gnt    = |gnt;
  assign g_id       = gnt[1];
  assign g_addr     = g_id ? req1_addr  : req0_addr;
  assign g_wdata    = g_id ? req1_wdata : req0_wdata;
  assign g_we       = g_id ? req1_we    : req0_we;
  assign g_lock     = g_id ? req1_lock  : req0_lock;
  assign g_mis      = is_misaligned(g_addr);

  // A misaligned write is still accepted, but it must never reach the RAM.
  assign mem_a2  = any_gnt ? g_addr : a2_q;
  assign mem_wd2 = any_gnt ? g_wdata : wd2_q;
  assign mem_we2 = (any_gnt && !g_mis) ? g_we : 4'h0;

  assign lock_hit = ({1'b0, lock_cnt_q} + 9'd1) >= LOCK_MAX_W;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    if (any_gnt) begin
      if (g_lock && !lock_hit) begin
        state_d    = g_id ? ST_LOCK1 : ST_LOCK0;
        lock_cnt_d = lock_cnt_q + 8'd1;
      end else begin
        state_d    = ST_IDLE;
        lock_cnt_d = 8'd0;
      end
    end else if (state_q == 2'd3) begin
      state_d    = ST_IDLE;
      lock_cnt_d = 8'd0;
    end
  end

  always_comb begin
    tag_d          = '0;
    tag_d.valid    = any_gnt;
    tag_d.req_id   = g_id;
    tag_d.is_write = (g_we != 4'h0);
    tag_d.err      = g_mis;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lock_cnt_q <= 8'd0;
      tag_q      <= '0;
      a2_q       <= 32'h0;
      wd2_q      <= 32'h0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      tag_q      <= tag_d;
      if (any_gnt) begin
        a2_q  <= g_addr;
        wd2_q <= g_wdata;
      end
    end
  end

  // RD2 belongs to whichever request the tag recorded last cycle.
  assign data_ok    = tag_q.valid && !tag_q.is_write && !tag_q.err;
  assign rsp0_valid = tag_q.valid && !tag_q.req_id;
  assign rsp1_valid = tag_q.valid && tag_q.req_id;
  assign rsp0_err   = rsp0_valid && tag_q.err;
  assign rsp1_err   = rsp1_valid && tag_q.err;
  assign rsp0_rdata = (rsp0_valid && data_ok) ? mem_rd2 : 32'h0;
  assign rsp1_rdata = (rsp1_valid && data_ok) ? mem_rd2 : 32'h0;

  assign fsm_state = state_q;

`ifdef IMEM_PORT_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat0_grants   <= 16'h0;
      stat1_grants   <= 16'h0;
      stat_conflicts <= 16'h0;
    end else begin
      if (gnt[0] && (stat0_grants != 16'hFFFF)) begin
        stat0_grants <= stat0_grants + 16'd1;
      end
      if (gnt[1] && (stat1_grants != 16'hFFFF)) begin
        stat1_grants <= stat1_grants + 16'd1;
      end
      // Both asking and one served: the loser waited a cycle.
      if (req0_valid && req1_valid && any_gnt && (stat_conflicts != 16'hFFFF)) begin
        stat_conflicts <= stat_conflicts + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a small behavioural RAM on port B and a
// response scoreboard per requester.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_addr = '0, req0_wdata = '0, req1_addr = '0, req1_wdata = '0;
  logic [3:0]  req0_we = '0, req1_we = '0;
  logic        req0_lock = 1'b0, req1_lock = 1'b0;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [31:0] mem_a2, mem_wd2, mem_rd2;
  logic [3:0]  mem_we2;
  logic [1:0]  fsm_state;
  logic        arb_ptr;

  logic        load_en = 1'b0;
  logic [5:0]  load_idx = '0;
  logic [31:0] load_data = '0;
  logic [31:0] ram [0:63];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic [64:0] exp0_q[$];
  logic [64:0] exp1_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_port_arbiter #(.PRIO_FIXED(0), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_we(req0_we), .req0_lock(req0_lock),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_we(req1_we), .req1_lock(req1_lock),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_a2(mem_a2), .mem_wd2(mem_wd2), .mem_we2(mem_we2), .mem_rd2(mem_rd2),
    .fsm_state(fsm_state), .arb_ptr(arb_ptr)
  );

  // Port-B RAM: byte-enable write, registered read.
  always @(posedge clk) begin
    if (load_en) begin
      ram[load_idx] <= load_data;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we2[b]) ram[mem_a2[7:2]][8*b +: 8] <= mem_wd2[8*b +: 8];
      end
    end
    mem_rd2 <= ram[mem_a2[7:2]];
  end

  function automatic logic [31:0] init_word(input int idx);
    case (idx)
      4:       return 32'hDEADBEEF;
      5:       return 32'h11111111;
      8:       return 32'hA0A0A0A0;
      9:       return 32'hB1B1B1B1;
      10:      return 32'hC2C2C2C2;
      11:      return 32'hD3D3D3D3;
      12:      return 32'hE4E4E4E4;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest expectation for that port.
  task automatic mon_port(input int id, input logic v, input logic [31:0] rd, input logic e);
    logic [64:0] ent;
    logic        have;
    if (v) begin
      checks++;
      have = (id == 0) ? (exp0_q.size() != 0) : (exp1_q.size() != 0);
      if (!have) begin
        errors++;
        $display("FAIL rsp%0d_unexpected: got pulse rdata=%h err=%b expected none", id, rd, e);
      end else begin
        ent = (id == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
        if ((32'(cyc) != ent[64:33] + 32'd1) || (rd !== ent[31:0]) || (e !== ent[32])) begin
          errors++;
          $display("FAIL rsp%0d: got cyc=%0d rdata=%h err=%b expected cyc=%0d rdata=%h err=%b",
                   id, cyc, rd, e, ent[64:33] + 32'd1, ent[31:0], ent[32]);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon_port(0, rsp0_valid, rsp0_rdata, rsp0_err);
    mon_port(1, rsp1_valid, rsp1_rdata, rsp1_err);
  end

  // Drive one cycle of requests, check the grant, and queue the expected response.
  task automatic issue(
    input logic v0, input logic [31:0] a0, input logic [31:0] wd0, input logic [3:0] we0,
    input logic l0,
    input logic v1, input logic [31:0] a1, input logic [31:0] wd1, input logic [3:0] we1,
    input logic l1,
    input logic e_rdy0, input logic e_rdy1, input logic [31:0] e_rd, input logic e_err,
    input logic [3:0] e_we2, input string name);
    req0_valid = v0; req0_addr = a0; req0_wdata = wd0; req0_we = we0; req0_lock = l0;
    req1_valid = v1; req1_addr = a1; req1_wdata = wd1; req1_we = we1; req1_lock = l1;
    #1;
    chk({name, "_rdy0"}, {31'h0, req0_ready}, {31'h0, e_rdy0});
    chk({name, "_rdy1"}, {31'h0, req1_ready}, {31'h0, e_rdy1});
    chk({name, "_we2"}, {28'h0, mem_we2}, {28'h0, e_we2});
    if (e_rdy0 || e_rdy1) chk({name, "_a2"}, mem_a2, e_rdy1 ? a1 : a0);
    if (e_rdy0) exp0_q.push_back({32'(cyc), e_err, e_rd});
    if (e_rdy1) exp1_q.push_back({32'(cyc), e_err, e_rd});
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_rdy"}, {30'h0, req1_ready, req0_ready}, 32'h0);
    chk({name, "_rspv"}, {30'h0, rsp1_valid, rsp0_valid}, 32'h0);
    chk({name, "_rsperr"}, {30'h0, rsp1_err, rsp0_err}, 32'h0);
    chk({name, "_rd0"}, rsp0_rdata, 32'h0);
    chk({name, "_rd1"}, rsp1_rdata, 32'h0);
    chk({name, "_a2"}, mem_a2, 32'h0);
    chk({name, "_wd2"}, mem_wd2, 32'h0);
    chk({name, "_we2"}, {28'h0, mem_we2}, 32'h0);
    chk({name, "_state"}, {30'h0, fsm_state}, 32'h0);
    chk({name, "_ptr"}, {31'h0, arb_ptr}, 32'h0);
  endtask

  initial begin
    // Clock/reset and RAM preload while reset is held.
    for (int i = 0; i < 64; i++) begin
      load_en = 1'b1; load_idx = 6'(i); load_data = init_word(i);
      @(posedge clk);
      #1;
    end
    load_en = 1'b0;
    check_all_zero("reset");
    rst = 1'b0;

    // Single reads from each requester.
    issue(1'b1, 32'h10, '0, 4'h0, 1'b0, 1'b0, '0, '0, 4'h0, 1'b0,
          1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 4'h0, "rd0");
    issue(1'b0, '0, '0, 4'h0, 1'b0, 1'b1, 32'h14, '0, 4'h0, 1'b0,
          1'b0, 1'b1, 32'h11111111, 1'b0, 4'h0, "rd1");

    // Round-robin alternation with both requesters valid.
    issue(1'b1, 32'h20, '0, 4'h0, 1'b0, 1'b1, 32'h24, '0, 4'h0, 1'b0,
          1'b1, 1'b0, 32'hA0A0A0A0, 1'b0, 4'h0, "rr_a");
    issue(1'b1, 32'h28, '0, 4'h0, 1'b0, 1'b1, 32'h24, '0, 4'h0, 1'b0,
          1'b0, 1'b1, 32'hB1B1B1B1, 1'b0, 4'h0, "rr_b");
    issue(1'b1, 32'h28, '0, 4'h0, 1'b0, 1'b1, 32'h2C, '0, 4'h0, 1'b0,
          1'b1, 1'b0, 32'hC2C2C2C2, 1'b0, 4'h0, "rr_c");
    issue(1'b1, 32'h30, '0, 4'h0, 1'b0, 1'b1, 32'h2C, '0, 4'h0, 1'b0,
          1'b0, 1'b1, 32'hD3D3D3D3, 1'b0, 4'h0, "rr_d");

    // Burst lock: three writes from requester 0 while requester 1 waits.
    issue(1'b1, 32'h0, 32'h11223344, 4'hF, 1'b1, 1'b1, 32'h10, '0, 4'h0, 1'b0,
          1'b1, 1'b0, 32'h0, 1'b0, 4'hF, "lk_w0");
    chk("lk_state0", {30'h0, fsm_state}, 32'd1);
    issue(1'b1, 32'h4, 32'h55667788, 4'hF, 1'b1, 1'b1, 32'h10, '0, 4'h0, 1'b0,
          1'b1, 1'b0, 32'h0, 1'b0, 4'hF, "lk_w1");
    chk("lk_state1", {30'h0, fsm_state}, 32'd1);
    issue(1'b1, 32'h8, 32'h99AABBCC, 4'hF, 1'b0, 1'b1, 32'h10, '0, 4'h0, 1'b0,
          1'b1, 1'b0, 32'h0, 1'b0, 4'hF, "lk_w2");
    chk("lk_state2", {30'h0, fsm_state}, 32'd0);
    issue(1'b0, '0, '0, 4'h0, 1'b0, 1'b1, 32'h10, '0, 4'h0, 1'b0,
          1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 4'h0, "lk_r1");

    // Forced release after LOCK_MAX=4 locked grants.
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 32'h0, '0, 4'h0, 1'b1, 1'b1, 32'h14, '0, 4'h0, 1'b0,
            1'b1, 1'b0, 32'h11223344, 1'b0, 4'h0, "lm_r0");
    end
    chk("lm_state", {30'h0, fsm_state}, 32'd0);
    issue(1'b1, 32'h0, '0, 4'h0, 1'b1, 1'b1, 32'h14, '0, 4'h0, 1'b0,
          1'b0, 1'b1, 32'h11111111, 1'b0, 4'h0, "lm_r1");
    issue(1'b0, '0, '0, 4'h0, 1'b0, 1'b0, '0, '0, 4'h0, 1'b0,
          1'b0, 1'b0, 32'h0, 1'b0, 4'h0, "idle");
    chk("a2_hold", mem_a2, 32'h14);

    // Misaligned write is suppressed and flagged; old data survives.
    issue(1'b0, '0, '0, 4'h0, 1'b0, 1'b1, 32'h6, 32'hFFFFFFFF, 4'hF, 1'b0,
          1'b0, 1'b1, 32'h0, 1'b1, 4'h0, "mis_w1");
    issue(1'b1, 32'h4, '0, 4'h0, 1'b0, 1'b0, '0, '0, 4'h0, 1'b0,
          1'b1, 1'b0, 32'h55667788, 1'b0, 4'h0, "mis_rb");

    // Reset right after a read grant drops the response.
    req0_valid = 1'b1; req0_addr = 32'h10; req0_we = 4'h0; req0_lock = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("rst_rdy0", {31'h0, req0_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req0_valid = 1'b0; req0_addr = '0;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(1'b0, '0, '0, 4'h0, 1'b0, 1'b1, 32'h24, '0, 4'h0, 1'b0,
          1'b0, 1'b1, 32'hB1B1B1B1, 1'b0, 4'h0, "rec_r1");
    issue(1'b0, '0, '0, 4'h0, 1'b0, 1'b0, '0, '0, 4'h0, 1'b0,
          1'b0, 1'b0, 32'h0, 1'b0, 4'h0, "tail");
    @(posedge clk);
    #1;
    chk("q0_drained", 32'(exp0_q.size()), 32'd0);
    chk("q1_drained", 32'(exp1_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
